// File: rtl/rf_wr_decoder_if.sv
// Bus bundle for the register-file write decoder: write requests in,
// decoded per-register enables, winning-port indices and conflict status out.
interface rf_wr_decoder_if #(
    parameter int ADDR_W = 5,
    parameter int NPORTS = 2
);
    localparam int NREGS  = 1 << ADDR_W;
    localparam int PSEL_W = (NPORTS <= 2) ? 1 : 2;

    logic                       stall;
    logic                       clr_cnt;
    logic [NPORTS-1:0]          wr_en;
    logic [NPORTS*ADDR_W-1:0]   wr_addr;
    logic [NREGS-1:0]           we_onehot;
    logic [NREGS*PSEL_W-1:0]    port_sel;
    logic                       conflict;
    logic [7:0]                 conflict_cnt;
    logic                       valid;

    modport master (
        output stall, clr_cnt, wr_en, wr_addr,
        input  we_onehot, port_sel, conflict, conflict_cnt, valid
    );

    modport slave (
        input  stall, clr_cnt, wr_en, wr_addr,
        output we_onehot, port_sel, conflict, conflict_cnt, valid
    );
endinterface

// File: rtl/rf_wr_decoder.sv
// Multi-port register-file write decoder: per-port address decode, merge with
// highest-port priority, conflict detection and a saturating conflict counter.
module rf_wr_decoder #(
    parameter int ADDR_W   = 5,
    parameter int NPORTS   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    rf_wr_decoder_if.slave     bus
);
    localparam int NREGS  = 1 << ADDR_W;
    localparam int PSEL_W = (NPORTS <= 2) ? 1 : 2;

    logic [NREGS-1:0]        port_hot [NPORTS];

    logic [NREGS-1:0]        we_dec;
    logic [NREGS*PSEL_W-1:0] sel_dec;
    logic                    conflict_dec;

    logic [NREGS-1:0]        we_onehot_d,    we_onehot_q;
    logic [NREGS*PSEL_W-1:0] port_sel_d,     port_sel_q;
    logic                    conflict_d,     conflict_q;
    logic                    valid_d,        valid_q;
    logic [7:0]              conflict_cnt_d, conflict_cnt_q;

    // Register 0 is masked per port so it can neither write nor raise a conflict.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            port_hot[p] = '0;
            if (bus.wr_en[p]) begin
                port_hot[p][bus.wr_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
            end
            if (ZERO_REG != 0) begin
                port_hot[p][0] = 1'b0;
            end
        end
    end

    // Ascending port scan: the last hit seen is the highest-numbered port.
    always_comb begin
        logic hit;
        we_dec       = '0;
        sel_dec      = '0;
        conflict_dec = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            hit = 1'b0;
            for (int p = 0; p < NPORTS; p++) begin
                if (port_hot[p][r]) begin
                    if (hit) begin
                        conflict_dec = 1'b1;
                    end
                    hit = 1'b1;
                    sel_dec[r*PSEL_W +: PSEL_W] = PSEL_W'(p);
                end
            end
            we_dec[r] = hit;
        end
    end

    always_comb begin
        we_onehot_d    = we_onehot_q;
        port_sel_d     = port_sel_q;
        conflict_d     = conflict_q;
        valid_d        = valid_q;
        conflict_cnt_d = conflict_cnt_q;
        if (!bus.stall) begin
            we_onehot_d = we_dec;
            port_sel_d  = sel_dec;
            conflict_d  = conflict_dec;
            valid_d     = |we_dec;
            if (conflict_dec && (conflict_cnt_q != 8'hFF)) begin
                conflict_cnt_d = conflict_cnt_q + 8'd1;
            end
        end
        // Clearing wins over both stall and a same-cycle increment.
        if (bus.clr_cnt) begin
            conflict_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_onehot_q    <= '0;
            port_sel_q     <= '0;
            conflict_q     <= 1'b0;
            valid_q        <= 1'b0;
            conflict_cnt_q <= 8'd0;
        end else begin
            we_onehot_q    <= we_onehot_d;
            port_sel_q     <= port_sel_d;
            conflict_q     <= conflict_d;
            valid_q        <= valid_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign bus.we_onehot    = we_onehot_q;
    assign bus.port_sel     = port_sel_q;
    assign bus.conflict     = conflict_q;
    assign bus.valid        = valid_q;
    assign bus.conflict_cnt = conflict_cnt_q;
endmodule

// File: tb/tb_rf_wr_decoder.sv
// Directed, table-driven bench for rf_wr_decoder; a second instance with
// ZERO_REG=0 shares the same stimulus to check register-0 handling.
module tb_rf_wr_decoder;
    logic clk;
    logic rst_n;

    rf_wr_decoder_if #(.ADDR_W(5), .NPORTS(2)) if0 ();
    rf_wr_decoder_if #(.ADDR_W(5), .NPORTS(2)) if1 ();

    rf_wr_decoder #(.ADDR_W(5), .NPORTS(2), .ZERO_REG(1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    rf_wr_decoder #(.ADDR_W(5), .NPORTS(2), .ZERO_REG(0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall;
        logic        clr;
        logic [1:0]  en;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] exp_we;
        logic [31:0] exp_sel;
        logic        exp_conf;
        logic [7:0]  exp_cnt;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[$];
    int   vec_count  = 0;
    int   miscompares = 0;

    task automatic drive(input logic st, input logic clr, input logic [1:0] en,
                         input logic [4:0] a0, input logic [4:0] a1);
        if0.stall   = st;
        if0.clr_cnt = clr;
        if0.wr_en   = en;
        if0.wr_addr = {a1, a0};
        if1.stall   = st;
        if1.clr_cnt = clr;
        if1.wr_en   = en;
        if1.wr_addr = {a1, a0};
    endtask

    task automatic applyStimulus(input logic st, input logic clr, input logic [1:0] en,
                                 input logic [4:0] a0, input logic [4:0] a1);
        drive(st, clr, en, a0, a1);
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] we, input logic [31:0] sel,
                               input logic conf, input logic [7:0] cnt, input logic v);
        checkVal({name, ".we_onehot"},    if0.we_onehot, we);
        checkVal({name, ".port_sel"},     if0.port_sel, sel);
        checkVal({name, ".conflict"},     32'(if0.conflict), 32'(conf));
        checkVal({name, ".conflict_cnt"}, 32'(if0.conflict_cnt), 32'(cnt));
        checkVal({name, ".valid"},        32'(if0.valid), 32'(v));
    endtask

    initial begin
        vecs.push_back('{"p0_addr5",      0, 0, 2'b01,  5,  0, 32'h0000_0020, 32'h0000_0000, 0, 8'd0, 1});
        vecs.push_back('{"both_addr7",    0, 0, 2'b11,  7,  7, 32'h0000_0080, 32'h0000_0080, 1, 8'd1, 1});
        vecs.push_back('{"split_3_9",     0, 0, 2'b11,  3,  9, 32'h0000_0208, 32'h0000_0200, 0, 8'd1, 1});
        vecs.push_back('{"p0_addr0",      0, 0, 2'b01,  0,  0, 32'h0000_0000, 32'h0000_0000, 0, 8'd1, 0});
        vecs.push_back('{"both_addr0",    0, 0, 2'b11,  0,  0, 32'h0000_0000, 32'h0000_0000, 0, 8'd1, 0});
        vecs.push_back('{"both_addr31",   0, 0, 2'b11, 31, 31, 32'h8000_0000, 32'h8000_0000, 1, 8'd2, 1});
        vecs.push_back('{"p1_only_addr4", 0, 0, 2'b10, 12,  4, 32'h0000_0010, 32'h0000_0010, 0, 8'd2, 1});
        vecs.push_back('{"idle",          0, 0, 2'b00,  9,  9, 32'h0000_0000, 32'h0000_0000, 0, 8'd2, 0});
        vecs.push_back('{"clr_split_1_2", 0, 1, 2'b11,  1,  2, 32'h0000_0006, 32'h0000_0004, 0, 8'd0, 1});
        vecs.push_back('{"clr_vs_incr",   0, 1, 2'b11,  6,  6, 32'h0000_0040, 32'h0000_0040, 1, 8'd0, 1});
        vecs.push_back('{"stall_a",       1, 0, 2'b11,  3,  4, 32'h0000_0040, 32'h0000_0040, 1, 8'd0, 1});
        vecs.push_back('{"stall_b",       1, 0, 2'b01,  8,  0, 32'h0000_0040, 32'h0000_0040, 1, 8'd0, 1});
        vecs.push_back('{"after_stall",   0, 0, 2'b01,  2,  0, 32'h0000_0004, 32'h0000_0000, 0, 8'd0, 1});

        rst_n = 1'b0;
        drive(0, 0, 2'b00, 0, 0);
        #2;
        checkOutput("reset_state", 32'h0, 32'h0, 0, 8'd0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].stall, vecs[i].clr, vecs[i].en, vecs[i].a0, vecs[i].a1);
            checkOutput(vecs[i].name, vecs[i].exp_we, vecs[i].exp_sel,
                        vecs[i].exp_conf, vecs[i].exp_cnt, vecs[i].exp_valid);
        end

        // Register 0 suppressed on dut0 but writable on dut1
        applyStimulus(0, 0, 2'b01, 0, 0);
        checkVal("zr1.we_onehot", if0.we_onehot, 32'h0);
        checkVal("zr1.valid",     32'(if0.valid), 32'd0);
        checkVal("zr0.we_onehot", if1.we_onehot, 32'h1);
        checkVal("zr0.valid",     32'(if1.valid), 32'd1);
        applyStimulus(0, 0, 2'b11, 0, 0);
        checkVal("zr0.conflict",  32'(if1.conflict), 32'd1);
        checkVal("zr0.port_sel",  if1.port_sel, 32'h1);
        checkVal("zr1.conflict",  32'(if0.conflict), 32'd0);

        // Conflict captured, then three stalled cycles with fresh writes
        applyStimulus(0, 0, 2'b11, 11, 11);
        checkOutput("stall_seq_capture", 32'h0000_0800, 32'h0000_0800, 1, 8'd1, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 2'b11, 5'(k + 1), 5'(k + 20));
            checkOutput("stall_seq_frozen", 32'h0000_0800, 32'h0000_0800, 1, 8'd1, 1);
        end
        applyStimulus(0, 0, 2'b10, 0, 13);
        checkOutput("stall_seq_release", 32'h0000_2000, 32'h0000_2000, 0, 8'd1, 1);

        // Saturation, then clear while the conflict persists
        for (int k = 0; k < 300; k++) begin
            applyStimulus(0, 0, 2'b11, 17, 17);
        end
        checkOutput("sat_255", 32'h0002_0000, 32'h0002_0000, 1, 8'd255, 1);
        applyStimulus(0, 1, 2'b11, 17, 17);
        checkOutput("sat_clear", 32'h0002_0000, 32'h0002_0000, 1, 8'd0, 1);
        applyStimulus(0, 0, 2'b11, 17, 17);
        checkOutput("post_clear_incr", 32'h0002_0000, 32'h0002_0000, 1, 8'd1, 1);

        // Asynchronous reset in the middle of a cycle
        applyStimulus(0, 0, 2'b01, 10, 0);
        checkOutput("pre_reset", 32'h0000_0400, 32'h0, 0, 8'd1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 32'h0, 32'h0, 0, 8'd0, 0);
        drive(0, 0, 2'b11, 5, 5);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("held_in_reset", 32'h0, 32'h0, 0, 8'd0, 0);
        drive(0, 0, 2'b00, 5, 5);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("first_edge_idle", 32'h0, 32'h0, 0, 8'd0, 0);
        applyStimulus(0, 0, 2'b01, 5, 0);
        checkOutput("resume_write", 32'h0000_0020, 32'h0, 0, 8'd0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule

// File: doc/rf_wr_decoder.md
RF_WR_DECODER -- requirements
Module: rf_wr_decoder

Interface
REQ-001 Parameter ADDR_W, default 5, register address width; NREGS = 2**ADDR_W registers decoded.
REQ-002 Parameter NPORTS, default 2, number of write ports (1..4); PSEL_W = 1 if NPORTS<=2, else 2.
REQ-003 Parameter ZERO_REG, default 1, when 1 writes addressed to register 0 are suppressed.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 stall  input  1  when 1, all registered outputs and the counter hold.
REQ-007 clr_cnt  input  1  synchronous clear of conflict_cnt.
REQ-008 wr_en  input  NPORTS  per-port write enable; bit p belongs to port p.
REQ-009 wr_addr  input  NPORTS*ADDR_W  per-port address; port p at bits [p*ADDR_W +: ADDR_W].
REQ-010 we_onehot  output  NREGS  registered decoded write-enable vector, at most one port's write per register.
REQ-011 port_sel  output  NREGS*PSEL_W  registered index of the winning port per register; register r at bits [r*PSEL_W +: PSEL_W].
REQ-012 conflict  output  1  registered; 1 when two or more enabled ports targeted the same non-suppressed register.
REQ-013 conflict_cnt  output  8  saturating count of cycles in which conflict was captured.
REQ-014 valid  output  1  registered; 1 when we_onehot has any bit set.

Function
REQ-015 Each port decodes: bit r of its one-hot is 1 iff wr_en[p]=1 and wr_addr[p]==r; all zero when wr_en[p]=0.
REQ-016 With ZERO_REG=1, bit 0 of every port's one-hot is forced 0 before merging, conflict and valid; with ZERO_REG=0, register 0 decodes like any other.
REQ-017 we_onehot[r] = OR over ports of bit r of each port's one-hot.
REQ-018 Priority: when several ports target register r, the highest-numbered enabled port wins; port_sel[r] holds its index.
REQ-019 port_sel[r] is 0 whenever we_onehot[r] is 0.
REQ-020 conflict is 1 iff any register has two or more ports targeting it after suppression.
REQ-021 Latency: outputs reflect the inputs sampled at the previous rising edge (exactly one cycle); no combinational path from inputs to outputs.
REQ-022 When stall=1 at an edge, we_onehot, port_sel, conflict, valid and conflict_cnt keep their values; inputs of that cycle are discarded.
REQ-023 When stall=0 and the captured conflict is 1, conflict_cnt increments by 1; at 255 it holds at 255 (no wrap).
REQ-024 clr_cnt=1 sets conflict_cnt to 0 at the next edge regardless of stall; clr_cnt overrides an increment in the same cycle.
REQ-025 NPORTS=1: conflict is permanently 0, port_sel all 0, and the block is a registered ADDR_W-to-NREGS decoder with enable.
REQ-026 Every address value 0..NREGS-1 is legal; there is no out-of-range case.

Reset
REQ-027 When rst_n goes low, we_onehot, port_sel, conflict, valid and conflict_cnt clear to 0 immediately, without waiting for clk.
REQ-028 While rst_n is low, stall, clr_cnt and write inputs are ignored; on the first rising edge after rst_n goes high, normal capture resumes.
REQ-029 Reset asserted mid-operation discards any captured write; no write is issued on the first edge after reset unless wr_en is high at that edge.

Verification
REQ-030 Defaults, port0 en, addr=5; port1 disabled -> next cycle we_onehot=0x00000020, port_sel[5]=0, valid=1, conflict=0.
REQ-031 Defaults, port0 addr=7 en, port1 addr=7 en -> we_onehot=0x00000080, port_sel[7]=1, conflict=1, conflict_cnt 0->1.
REQ-032 ZERO_REG=1, port0 en addr=0 only -> we_onehot=0, valid=0; with ZERO_REG=0 same stimulus -> we_onehot=0x00000001, valid=1.
REQ-033 Capture conflict, then stall=1 for 3 cycles with new non-conflicting writes -> outputs and conflict_cnt frozen; stall=0 -> new write appears one cycle later.
REQ-034 Hold conflicting writes for 300 cycles -> conflict_cnt saturates at 255; pulse clr_cnt with conflict still present -> conflict_cnt=0 next edge.
REQ-035 Active write with valid=1, drop rst_n between edges -> all outputs 0 immediately; release -> first edge with wr_en=0 yields valid=0.
